// File: rtl/uart_tx_arb.sv
// Round-robin whole-message arbiter for two writers onto the UART TX FIFO; optional idle-owner timeout via UART_ARB_TIMEOUT_EN.
// Grant 1 cycle after req from IDLE; data path zero latency; rdy drops combinationally with tx_fifo_full.
module uart_tx_arb #(
    parameter logic [19:0] TIMEOUT = 20'd200000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    input  logic       i_wten0,
    input  logic       i_wten1,
    input  logic       i_last0,
    input  logic       i_last1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_rdy0,
    output logic       o_rdy1,
    output logic [7:0] o_tx_wdata,
    output logic       o_tx_wten,
    input  logic       i_tx_fifo_full,
    output logic [7:0] o_drop_cnt,
    output logic       o_timeout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_last_owner;
    logic [7:0] r_drop_cnt;
    logic       r_timeout;

    logic w_rdy0;
    logic w_rdy1;
    logic w_acc0;
    logic w_acc1;
    logic w_drop;
    logic w_to_hit;

    assign w_rdy0 = r_gnt0 & ~i_tx_fifo_full;
    assign w_rdy1 = r_gnt1 & ~i_tx_fifo_full;
    assign w_acc0 = i_wten0 & w_rdy0;
    assign w_acc1 = i_wten1 & w_rdy1;
    assign w_drop = (i_wten0 & ~w_rdy0) | (i_wten1 & ~w_rdy1);

`ifdef UART_ARB_TIMEOUT_EN
    logic [19:0] r_to_cnt;

    // Fires on the cycle the count would reach TIMEOUT; an accepted write that cycle wins instead.
    assign w_to_hit = (r_gnt0 | r_gnt1) & ~i_tx_fifo_full & ~(w_acc0 | w_acc1)
                    & (r_to_cnt == TIMEOUT - 20'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= 20'd0;
        end else if ((w_next != r_state) || w_acc0 || w_acc1) begin
            r_to_cnt <= 20'd0;
        end else if ((r_state != IDLE) && !i_tx_fifo_full) begin
            r_to_cnt <= r_to_cnt + 20'd1;
        end
    end
`else
    assign w_to_hit = &{1'b0, TIMEOUT};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req0 && (!i_req1 || r_last_owner))
                    w_next = OWN0;
                else if (i_req1)
                    w_next = OWN1;
            end
            OWN0: begin
                if ((w_acc0 && i_last0) || !i_req0 || w_to_hit) begin
                    if (i_req1)
                        w_next = OWN1;
                    else if (w_acc0 && i_last0 && i_req0)
                        w_next = OWN0;
                    else
                        w_next = IDLE;
                end
            end
            OWN1: begin
                if ((w_acc1 && i_last1) || !i_req1 || w_to_hit) begin
                    if (i_req0)
                        w_next = OWN0;
                    else if (w_acc1 && i_last1 && i_req1)
                        w_next = OWN1;
                    else
                        w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_last_owner <= 1'b1;
            r_drop_cnt   <= 8'd0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gnt0    <= (w_next == OWN0);
            r_gnt1    <= (w_next == OWN1);
            r_timeout <= w_to_hit;
            // Any exit from an OWN state records that owner, even when it is immediately re-granted.
            if (r_state == OWN0 && w_next != OWN0)
                r_last_owner <= 1'b0;
            else if (r_state == OWN1 && w_next != OWN1)
                r_last_owner <= 1'b1;
            else if (r_state == OWN0 && w_acc0 && i_last0)
                r_last_owner <= 1'b0;
            else if (r_state == OWN1 && w_acc1 && i_last1)
                r_last_owner <= 1'b1;
            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_rdy0     = w_rdy0;
    assign o_rdy1     = w_rdy1;
    assign o_tx_wten  = w_acc0 | w_acc1;
    assign o_tx_wdata = r_gnt0 ? i_wdata0 : (r_gnt1 ? i_wdata1 : 8'd0);
    assign o_drop_cnt = r_drop_cnt;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: vector table for arbitration/data path, scoreboard on tx writes, hand sequences for saturation, reset and timeout.
module tb_uart_tx_arb;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, wten0, wten1, last0, last1, full;
    logic [7:0] wd0, wd1;
    logic       o_gnt0, o_gnt1, o_rdy0, o_rdy1, o_tx_wten, o_timeout;
    logic [7:0] o_tx_wdata, o_drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [6:0] ctl;   // {req0, req1, wten0, wten1, last0, last1, full}
        logic [7:0] d0;
        logic [7:0] d1;
        logic [4:0] eo;    // {gnt0, gnt1, rdy0, rdy1, tx_wten}
        logic [7:0] txd;
        logic [7:0] drop;
    } vec_t;

    vec_t vq[$];

    uart_tx_arb #(.TIMEOUT(20'd16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .i_wdata0(wd0), .i_wdata1(wd1),
        .i_wten0(wten0), .i_wten1(wten1),
        .i_last0(last0), .i_last1(last1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rdy0(o_rdy0), .o_rdy1(o_rdy1),
        .o_tx_wdata(o_tx_wdata), .o_tx_wten(o_tx_wten),
        .i_tx_fifo_full(full),
        .o_drop_cnt(o_drop_cnt), .o_timeout(o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] c, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [4:0] eo, input logic [7:0] txd, input logic [7:0] drop);
        vec_t v;
        v.ctl = c; v.d0 = d0; v.d1 = d1; v.eo = eo; v.txd = txd; v.drop = drop;
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {10'd0, o_gnt0, o_gnt1, o_rdy0, o_rdy1, o_tx_wten, o_tx_wdata, o_drop_cnt, o_timeout};
    endfunction

    task automatic drive(input logic [6:0] c, input logic [7:0] d0, input logic [7:0] d1);
        {req0, req1, wten0, wten1, last0, last1, full} = c;
        wd0 = d0;
        wd1 = d1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (o_tx_wten) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write %h expected none", o_tx_wdata);
            end else begin
                chk("sb_data", {24'd0, o_tx_wdata}, {24'd0, exp_q.pop_front()});
            end
        end
        if (full)
            chk("wten_while_full", {31'd0, o_tx_wten}, 32'd0);
    end

    initial begin
        int bad;

        // Round A: tie after reset goes to 0, handoff to 1 with no gap.
        vq.push_back(mk(7'b1100000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd0));
        vq.push_back(mk(7'b1110000, 8'h10, 8'h00, 5'b10101, 8'h10, 8'd0));
        vq.push_back(mk(7'b1110100, 8'h11, 8'h00, 5'b10101, 8'h11, 8'd0));
        vq.push_back(mk(7'b0001010, 8'h00, 8'h20, 5'b01011, 8'h20, 8'd0));
        vq.push_back(mk(7'b0000000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd0));
        // Requester 0 alone: 41 42 43, then IDLE.
        vq.push_back(mk(7'b1000000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd0));
        vq.push_back(mk(7'b1010000, 8'h41, 8'h00, 5'b10101, 8'h41, 8'd0));
        vq.push_back(mk(7'b1010000, 8'h42, 8'h00, 5'b10101, 8'h42, 8'd0));
        vq.push_back(mk(7'b0010100, 8'h43, 8'h00, 5'b10101, 8'h43, 8'd0));
        vq.push_back(mk(7'b0000000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd0));
        // Round B: tie now goes to 1; illegal writes, full back-pressure, re-grant on last with req held.
        vq.push_back(mk(7'b1100000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd0));
        vq.push_back(mk(7'b1110000, 8'h55, 8'h33, 5'b01010, 8'h33, 8'd0));
        vq.push_back(mk(7'b1101010, 8'h00, 8'h21, 5'b01011, 8'h21, 8'd1));
        vq.push_back(mk(7'b1001000, 8'h00, 8'h55, 5'b10100, 8'h00, 8'd1));
        vq.push_back(mk(7'b1010001, 8'h60, 8'h00, 5'b10000, 8'h60, 8'd2));
        vq.push_back(mk(7'b1000001, 8'h00, 8'h00, 5'b10000, 8'h00, 8'd3));
        vq.push_back(mk(7'b1010100, 8'h61, 8'h00, 5'b10101, 8'h61, 8'd3));
        vq.push_back(mk(7'b0000000, 8'h00, 8'h00, 5'b10100, 8'h00, 8'd3));
        vq.push_back(mk(7'b0000000, 8'h00, 8'h00, 5'b00000, 8'h00, 8'd3));

        rst_n = 1'b0;
        drive(7'b0000000, 8'h00, 8'h00);
        repeat (2) cyc();
        chk("reset_state", outs(), 32'd0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc();
            drive(vq[i].ctl, vq[i].d0, vq[i].d1);
            if (vq[i].eo[0])
                exp_q.push_back(vq[i].txd);
            #2;
            chk($sformatf("row%0d", i), outs(), {10'd0, vq[i].eo, vq[i].txd, vq[i].drop, 1'b0});
        end

        // Both requesters write illegally in one cycle: a single increment.
        cyc();
        drive(7'b0011000, 8'h01, 8'h02);
        cyc();
        drive(7'b0000000, 8'h00, 8'h00);
        #2;
        chk("drop_both", {24'd0, o_drop_cnt}, 32'd4);

        // 300 illegal writes saturate the counter.
        cyc();
        drive(7'b0001000, 8'h00, 8'h55);
        repeat (299) cyc();
        cyc();
        drive(7'b0000000, 8'h00, 8'h00);
        #2;
        chk("drop_sat", {24'd0, o_drop_cnt}, 32'hFF);

        // Reset two bytes into a four-byte message.
        cyc();
        drive(7'b1000000, 8'h00, 8'h00);
        cyc();
        drive(7'b1010000, 8'hA0, 8'h00);
        exp_q.push_back(8'hA0);
        cyc();
        drive(7'b1010000, 8'hA1, 8'h00);
        exp_q.push_back(8'hA1);
        cyc();
        rst_n = 1'b0;
        drive(7'b1010000, 8'hA2, 8'h00);
        #1;
        chk("reset_mid_msg", outs(), 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(7'b1100000, 8'h00, 8'h00);
        cyc();
        #2;
        chk("restart_pref0", {30'd0, o_gnt0, o_gnt1}, 32'b10);
        drive(7'b0000000, 8'h00, 8'h00);
        cyc();
        cyc();
        #2;
        chk("back_to_idle", {30'd0, o_gnt0, o_gnt1}, 32'b00);

        // Owner holds req and never writes.
        cyc();
        drive(7'b1000000, 8'h00, 8'h00);
        cyc();
        #2;
        chk("to_grant", {31'd0, o_gnt0}, 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            cyc();
            #2;
            if (!o_gnt0 || o_timeout)
                bad++;
        end
        chk("to_hold", bad, 0);
        cyc();
        #2;
        chk("to_pulse", {30'd0, o_gnt0, o_timeout}, 32'b01);
        cyc();
        #2;
        chk("to_regrant", {30'd0, o_gnt0, o_timeout}, 32'b10);
        full = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            #2;
            if (!o_gnt0 || o_timeout)
                bad++;
        end
        chk("full_no_to", bad, 0);
        full = 1'b0;
`else
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            #2;
            if (!o_gnt0 || o_timeout)
                bad++;
        end
        chk("no_to_hold", bad, 0);
`endif
        cyc();
        drive(7'b0000000, 8'h00, 8'h00);
        repeat (2) cyc();
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-requester arbiter sharing the monitor UART transmit FIFO (`uart_if` write side: `tx_wdata`/`tx_wten`/`tx_fifo_full`). It sits between the monitor command responder (requester 0) and the CPU character-output path (requester 1). It grants whole messages with round-robin fairness, so bytes from two sources never interleave inside a message. Writes pass through combinationally, so the FIFO is never overrun.

## Interface
- `TIMEOUT`, default 20'd200000: idle-owner cycles before forced release (4 byte times at 48 MHz/9600 bps); used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  requester wants ownership; held high for the whole message.
- `wdata0`, `wdata1`  in  8  byte from the requester.
- `wten0`, `wten1`  in  1  write strobe; a byte is accepted when `wtenN & rdyN`.
- `last0`, `last1`  in  1  qualifies `wtenN`: the byte is the final byte of the message.
- `gnt0`, `gnt1`  out  1  registered grant; at most one is high.
- `rdy0`, `rdy1`  out  1  `gntN & ~tx_fifo_full`.
- `tx_wdata`  out  8  to `uart_if`; the owner's `wdata`, 8'd0 when idle.
- `tx_wten`  out  1  to `uart_if`; `wtenN & rdyN` of the owner.
- `tx_fifo_full`  in  1  from `uart_if`.
- `drop_cnt`  out  8  saturating count of rejected writes.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, OWN0, OWN1; `gnt0 = (state==OWN0)`, `gnt1 = (state==OWN1)`.
- Pointer `last_owner` (1 bit), reset to 1, so requester 0 wins the first tie.
- IDLE: if one request is high, move to that requester's OWN state. If both are high, grant `~last_owner`. If neither is high, stay in IDLE.
- OWNn release events:
  - (a) an accepted write with `lastn`;
  - (b) `reqn` low;
  - (c) timeout (only with the macro).
- On release, `last_owner <= n`. The next state is chosen in this order:
  - OWN(other) if the other requester's `req` is high;
  - else OWNn if the release was (a) and `reqn` is still high;
  - else IDLE.
- A write from a requester without `rdy` is rejected: it is not forwarded and `drop_cnt` increments, saturating at 8'hFF. If both requesters write illegally in the same cycle, `drop_cnt` increments by 1.
- A write with `wten` high while `tx_fifo_full` is high and the requester is granted also counts as a drop. Requesters must honour `rdy`.
- `tx_wten` can never be high while `tx_fifo_full` is high.

## Timing
- Reset values: state IDLE, `gnt0`/`gnt1` = 0, `rdy0`/`rdy1` = 0, `tx_wten` = 0, `tx_wdata` = 0, `drop_cnt` = 0, `timeout` = 0, `last_owner` = 1.
- Grant latency: `req` high in cycle T gives `gnt` high in T+1 when starting from IDLE.
- Data path is zero-latency combinational: `wdata`/`wten` in cycle T appear on `tx_wdata`/`tx_wten` in cycle T. The FIFO write lands at the edge ending T.
- Handoff: the last accepted byte in cycle T moves `gnt` to the waiting requester at T+1, with no idle gap.
- A requester dropping `req` mid-message releases at the next edge. Any partial message already queued is not retracted.
- Reset asserted mid-message: everything returns to reset values immediately. Bytes already written stay in the `uart_if` FIFO.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - a 20-bit counter clears on grant entry and on each accepted write;
  - it holds while `tx_fifo_full` is high and otherwise increments while in OWNn;
  - at count == `TIMEOUT - 1` it forces release (c) and pulses `timeout` for one cycle.
- Not defined: no counter is built, `timeout` is tied to 0, and ownership lasts until (a) or (b).

## Test plan
- Reset, then `req0` alone writes 3 bytes 8'h41, 8'h42, 8'h43 (`last` on 8'h43) → `gnt0` high one cycle after `req0`. `tx_wten` pulses 3 times with matching data. State is IDLE after the last byte.
- `req0` and `req1` rise in the same cycle → `gnt0` first. After `last0` is accepted, `gnt1` is high in the next cycle. A second simultaneous round grants requester 1 first.
- Requester 1 writes 8'h55 while requester 0 owns → `tx_wten` stays 0 and `drop_cnt` = 1. 300 illegal writes → `drop_cnt` = 8'hFF.
- Hold `tx_fifo_full` = 1 during ownership → `rdy0` = 0 and `tx_wten` never rises. Deassert full → `rdy0` = 1 in the same cycle.
- With the macro and `TIMEOUT` = 20'd16: owner holds `req` and never writes → forced release and `timeout` pulse 16 cycles after grant. With `tx_fifo_full` held, no timeout occurs.
- Assert `rst_n` = 0 while 2 bytes into a 4-byte message → all outputs return to reset values asynchronously. After release, arbitration restarts with requester 0 preferred.
